// File: rtl/arm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared types and constants for the multicycle ARM control unit:
//   - mc_state_t : control FSM state encoding
//   - ALU_*      : ALUControl encodings
//   - CMD_*      : data-processing cmd field (Funct[4:1]) values
//   - SRCB_*/RES_* : ALUSrcB and ResultSrc select encodings
//   - moore_t / moore_outs() : per-state Moore output bundle
//   - next_state() : FSM transition function
// No ports (package).
// -----------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } mc_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic       next_pc;
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       reg_w;
        logic       mem_w;
        logic       alu_op;
        logic       branch;
    } moore_t;

    // alu_op stays high through ALUWB so the ALU decode (and NoWrite) seen
    // alongside RegW belongs to the instruction being written back.
    function automatic moore_t moore_outs(input mc_state_t s);
        moore_t o;
        o = '0;
        case (s)
            FETCH: begin
                o.ir_write   = 1'b1;
                o.next_pc    = 1'b1;
                o.alu_src_a  = 1'b1;
                o.alu_src_b  = SRCB_FOUR;
                o.result_src = RES_ALURESULT;
            end
            DECODE: begin
                o.alu_src_a  = 1'b1;
                o.alu_src_b  = SRCB_FOUR;
                o.result_src = RES_ALURESULT;
            end
            MEMADR:   o.alu_src_b = SRCB_IMM;
            MEMREAD:  o.adr_src   = 1'b1;
            MEMWB: begin
                o.result_src = RES_DATA;
                o.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                o.adr_src = 1'b1;
                o.mem_w   = 1'b1;
            end
            EXECUTER: o.alu_op = 1'b1;
            EXECUTEI: begin
                o.alu_src_b = SRCB_IMM;
                o.alu_op    = 1'b1;
            end
            ALUWB: begin
                o.reg_w  = 1'b1;
                o.alu_op = 1'b1;
            end
            BRANCH: begin
                o.alu_src_b  = SRCB_IMM;
                o.result_src = RES_ALURESULT;
                o.branch     = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic mc_state_t next_state(input mc_state_t s, input logic [1:0] op,
                                             input logic imm, input logic load);
        mc_state_t n;
        n = FETCH;
        case (s)
            FETCH:  n = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   n = MEMADR;
                    2'b00:   n = imm ? EXECUTEI : EXECUTER;
                    2'b10:   n = BRANCH;
                    default: n = FETCH;
                endcase
            end
            MEMADR:   n = load ? MEMREAD : MEMWRITE;
            MEMREAD:  n = MEMWB;
            EXECUTER: n = ALUWB;
            EXECUTEI: n = ALUWB;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/multicycle_decoder_if.sv
// -----------------------------------------------------------------------------
// multicycle_decoder_if
// Instruction-field inputs and control outputs of the multicycle decoder.
//   slave  : decoder side (Op/Funct/Rd in, control out)
//   master : instruction-register / datapath side
// -----------------------------------------------------------------------------
interface multicycle_decoder_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic [1:0] FlagW;
    logic       NextPC;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;

    modport slave (
        input  Op, Funct, Rd,
        output PCS, RegW, MemW, NoWrite, FlagW, NextPC, IRWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc
    );

    modport master (
        output Op, Funct, Rd,
        input  PCS, RegW, MemW, NoWrite, FlagW, NextPC, IRWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc
    );
endinterface

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational ALU control decode for data-processing instructions.
// Ports:
//   alu_op      in  : 1 while a data-processing instruction is executing/writing
//   cmd         in 4: Funct[4:1]
//   s_bit       in  : Funct[0] (set-flags)
//   alu_control out 2, flag_w out 2 ([1]=NZ, [0]=CV), no_write out 1
// Build option: MULTICYCLE_CMP_EN enables CMP decode (SUB with NoWrite).
// -----------------------------------------------------------------------------
module alu_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       alu_op,
    input  logic [3:0] cmd,
    input  logic       s_bit,
    output logic [1:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_write
);

    logic known;

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        no_write    = 1'b0;
        known       = 1'b0;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: begin alu_control = ALU_ADD; known = 1'b1; end
                CMD_SUB: begin alu_control = ALU_SUB; known = 1'b1; end
                CMD_AND: begin alu_control = ALU_AND; known = 1'b1; end
                CMD_ORR: begin alu_control = ALU_ORR; known = 1'b1; end
                default: begin alu_control = ALU_ADD; known = 1'b0; end
            endcase
`ifdef MULTICYCLE_CMP_EN
            if (cmd == CMD_CMP) begin
                alu_control = ALU_SUB;
                no_write    = 1'b1;
                known       = 1'b1;
            end
`else
            no_write = 1'b0;
`endif
        end
        // Unrecognised commands never touch the flags.
        if (known) begin
            flag_w[1] = s_bit;
            flag_w[0] = s_bit & ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));
        end
    end

endmodule

// File: rtl/multicycle_decoder.sv
// -----------------------------------------------------------------------------
// multicycle_decoder
// Control FSM + instruction decoder for the multicycle ARM core.
// Ports:
//   clk   in : rising-edge clock
//   reset in : synchronous active-high, forces FETCH
//   dec      : multicycle_decoder_if.slave (Op/Funct/Rd in; PCS, RegW, MemW,
//              NoWrite, FlagW, NextPC, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
//              ResultSrc, ALUControl, ImmSrc, RegSrc out)
// Build option: MULTICYCLE_CMP_EN (inside alu_decoder) enables CMP decode.
// Moore outputs are registered alongside the state; PCS, ALU decode,
// ImmSrc and RegSrc follow Op/Funct/Rd combinationally.
// -----------------------------------------------------------------------------
module multicycle_decoder
    import arm_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_decoder_if.slave   dec
);

    mc_state_t state;
    moore_t    outs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            outs  <= moore_outs(FETCH);
        end else begin
            state <= next_state(state, dec.Op, dec.Funct[5], dec.Funct[0]);
            outs  <= moore_outs(next_state(state, dec.Op, dec.Funct[5], dec.Funct[0]));
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (outs.alu_op),
        .cmd         (dec.Funct[4:1]),
        .s_bit       (dec.Funct[0]),
        .alu_control (dec.ALUControl),
        .flag_w      (dec.FlagW),
        .no_write    (dec.NoWrite)
    );

    assign dec.NextPC    = outs.next_pc;
    assign dec.IRWrite   = outs.ir_write;
    assign dec.AdrSrc    = outs.adr_src;
    assign dec.ALUSrcA   = outs.alu_src_a;
    assign dec.ALUSrcB   = outs.alu_src_b;
    assign dec.ResultSrc = outs.result_src;
    assign dec.RegW      = outs.reg_w;
    assign dec.MemW      = outs.mem_w;

    // A write to R15 is a PC write, as is any branch.
    assign dec.PCS    = (outs.reg_w & (dec.Rd == 4'hF)) | outs.branch;
    assign dec.ImmSrc = dec.Op;
    assign dec.RegSrc = {dec.Op == 2'b01, dec.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_decoder.sv
module tb_multicycle_decoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_decoder_if dif ();
    multicycle_decoder dut (.clk(clk), .reset(reset), .dec(dif));

`ifdef MULTICYCLE_CMP_EN
    localparam logic [1:0] CMP_ALUC = 2'b01;
    localparam logic       CMP_NW   = 1'b1;
    localparam logic [1:0] CMP_FW   = 2'b11;
`else
    localparam logic [1:0] CMP_ALUC = 2'b00;
    localparam logic       CMP_NW   = 1'b0;
    localparam logic [1:0] CMP_FW   = 2'b00;
`endif

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [19:0] exp;
    } rec_t;

    rec_t tbl[$];
    int   nerr = 0;
    int   nchk = 0;

    // {PCS,RegW,MemW,NoWrite,FlagW,NextPC,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,ImmSrc,RegSrc}
    function automatic logic [19:0] ev(input logic [1:0] op, input logic pcs, input logic regw,
                                       input logic memw, input logic nw, input logic [1:0] fw,
                                       input logic npc, input logic irw, input logic adr,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] rs, input logic [1:0] aluc);
        return {pcs, regw, memw, nw, fw, npc, irw, adr, asa, asb, rs, aluc, op,
                (op == 2'b01), (op == 2'b10)};
    endfunction

    function automatic logic [19:0] e_fetch(input logic [1:0] op);
        return ev(op, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00);
    endfunction
    function automatic logic [19:0] e_decode(input logic [1:0] op);
        return ev(op, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00);
    endfunction
    function automatic logic [19:0] e_memadr(input logic [1:0] op);
        return ev(op, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
    endfunction
    function automatic logic [19:0] e_memrd(input logic [1:0] op);
        return ev(op, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    endfunction
    function automatic logic [19:0] e_memwb(input logic [1:0] op, input logic pcs);
        return ev(op, pcs, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
    endfunction
    function automatic logic [19:0] e_memwr(input logic [1:0] op);
        return ev(op, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    endfunction
    function automatic logic [19:0] e_exr(input logic [1:0] aluc, input logic nw, input logic [1:0] fw);
        return ev(2'b00, 1'b0, 1'b0, 1'b0, nw, fw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, aluc);
    endfunction
    function automatic logic [19:0] e_exi(input logic [1:0] aluc, input logic nw, input logic [1:0] fw);
        return ev(2'b00, 1'b0, 1'b0, 1'b0, nw, fw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, aluc);
    endfunction
    function automatic logic [19:0] e_aluwb(input logic pcs, input logic [1:0] aluc, input logic nw,
                                            input logic [1:0] fw);
        return ev(2'b00, pcs, 1'b1, 1'b0, nw, fw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, aluc);
    endfunction
    function automatic logic [19:0] e_branch();
        return ev(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00);
    endfunction

    function automatic logic [19:0] act();
        return {dif.PCS, dif.RegW, dif.MemW, dif.NoWrite, dif.FlagW, dif.NextPC, dif.IRWrite,
                dif.AdrSrc, dif.ALUSrcA, dif.ALUSrcB, dif.ResultSrc, dif.ALUControl,
                dif.ImmSrc, dif.RegSrc};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        logic [19:0] a;
        a = act();
        nchk++;
        if (a !== exp) begin
            nerr++;
            $display("FAIL %s: got %05h expected %05h", name, a, exp);
        end
    endtask

    task automatic add(input string n, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd, input logic [19:0] e);
        rec_t r;
        r.name = n; r.op = op; r.funct = f; r.rd = rd; r.exp = e;
        tbl.push_back(r);
    endtask

    task automatic step(input string name, input logic [19:0] exp);
        @(negedge clk);
        #1;
        check(name, exp);
    endtask

    initial begin
        // LDR r3
        add("ldr_fetch",   2'b01, 6'b011001, 4'd3, e_fetch(2'b01));
        add("ldr_decode",  2'b01, 6'b011001, 4'd3, e_decode(2'b01));
        add("ldr_memadr",  2'b01, 6'b011001, 4'd3, e_memadr(2'b01));
        add("ldr_memread", 2'b01, 6'b011001, 4'd3, e_memrd(2'b01));
        add("ldr_memwb",   2'b01, 6'b011001, 4'd3, e_memwb(2'b01, 1'b0));
        // STR
        add("str_fetch",   2'b01, 6'b011000, 4'd3, e_fetch(2'b01));
        add("str_decode",  2'b01, 6'b011000, 4'd3, e_decode(2'b01));
        add("str_memadr",  2'b01, 6'b011000, 4'd3, e_memadr(2'b01));
        add("str_memwr",   2'b01, 6'b011000, 4'd3, e_memwr(2'b01));
        // ADDS r15 (register)
        add("adds_fetch",  2'b00, 6'b001001, 4'hF, e_fetch(2'b00));
        add("adds_decode", 2'b00, 6'b001001, 4'hF, e_decode(2'b00));
        add("adds_exr",    2'b00, 6'b001001, 4'hF, e_exr(2'b00, 1'b0, 2'b11));
        add("adds_aluwb",  2'b00, 6'b001001, 4'hF, e_aluwb(1'b1, 2'b00, 1'b0, 2'b11));
        // LDR r15
        add("ldrpc_fetch",   2'b01, 6'b011001, 4'hF, e_fetch(2'b01));
        add("ldrpc_decode",  2'b01, 6'b011001, 4'hF, e_decode(2'b01));
        add("ldrpc_memadr",  2'b01, 6'b011001, 4'hF, e_memadr(2'b01));
        add("ldrpc_memread", 2'b01, 6'b011001, 4'hF, e_memrd(2'b01));
        add("ldrpc_memwb",   2'b01, 6'b011001, 4'hF, e_memwb(2'b01, 1'b1));
        // ORR r2 (register, no S)
        add("orr_fetch",   2'b00, 6'b011000, 4'd2, e_fetch(2'b00));
        add("orr_decode",  2'b00, 6'b011000, 4'd2, e_decode(2'b00));
        add("orr_exr",     2'b00, 6'b011000, 4'd2, e_exr(2'b11, 1'b0, 2'b00));
        add("orr_aluwb",   2'b00, 6'b011000, 4'd2, e_aluwb(1'b0, 2'b11, 1'b0, 2'b00));
        // ANDS r1 (immediate)
        add("ands_fetch",  2'b00, 6'b100001, 4'd1, e_fetch(2'b00));
        add("ands_decode", 2'b00, 6'b100001, 4'd1, e_decode(2'b00));
        add("ands_exi",    2'b00, 6'b100001, 4'd1, e_exi(2'b10, 1'b0, 2'b10));
        add("ands_aluwb",  2'b00, 6'b100001, 4'd1, e_aluwb(1'b0, 2'b10, 1'b0, 2'b10));
        // SUBS r4 (register)
        add("subs_fetch",  2'b00, 6'b000101, 4'd4, e_fetch(2'b00));
        add("subs_decode", 2'b00, 6'b000101, 4'd4, e_decode(2'b00));
        add("subs_exr",    2'b00, 6'b000101, 4'd4, e_exr(2'b01, 1'b0, 2'b11));
        add("subs_aluwb",  2'b00, 6'b000101, 4'd4, e_aluwb(1'b0, 2'b01, 1'b0, 2'b11));
        // EORS (cmd 0001, not decoded)
        add("eor_fetch",   2'b00, 6'b000011, 4'd5, e_fetch(2'b00));
        add("eor_decode",  2'b00, 6'b000011, 4'd5, e_decode(2'b00));
        add("eor_exr",     2'b00, 6'b000011, 4'd5, e_exr(2'b00, 1'b0, 2'b00));
        add("eor_aluwb",   2'b00, 6'b000011, 4'd5, e_aluwb(1'b0, 2'b00, 1'b0, 2'b00));
        // CMP immediate
        add("cmp_fetch",   2'b00, 6'b110101, 4'd0, e_fetch(2'b00));
        add("cmp_decode",  2'b00, 6'b110101, 4'd0, e_decode(2'b00));
        add("cmp_exi",     2'b00, 6'b110101, 4'd0, e_exi(CMP_ALUC, CMP_NW, CMP_FW));
        add("cmp_aluwb",   2'b00, 6'b110101, 4'd0, e_aluwb(1'b0, CMP_ALUC, CMP_NW, CMP_FW));
        // B
        add("b_fetch",     2'b10, 6'b101000, 4'd0, e_fetch(2'b10));
        add("b_decode",    2'b10, 6'b101000, 4'd0, e_decode(2'b10));
        add("b_branch",    2'b10, 6'b101000, 4'd0, e_branch());
        // Undefined Op=11 with Rd=15: no side effects
        add("undef_fetch",  2'b11, 6'b011001, 4'hF, e_fetch(2'b11));
        add("undef_decode", 2'b11, 6'b011001, 4'hF, e_decode(2'b11));
        add("undef_refetch", 2'b00, 6'b000000, 4'd0, e_fetch(2'b00));

        dif.Op = 2'b00; dif.Funct = 6'b000000; dif.Rd = 4'd0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("reset_state", e_fetch(2'b00));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            dif.Op = tbl[i].op; dif.Funct = tbl[i].funct; dif.Rd = tbl[i].rd;
            #1;
            check(tbl[i].name, tbl[i].exp);
        end

        // Reset while in DECODE of a data-processing instruction aborts it.
        @(negedge clk);
        reset = 1'b1;
        dif.Op = 2'b01; dif.Funct = 6'b011001; dif.Rd = 4'd3;
        #1 check("rst_in_decode_no_comb", e_decode(2'b01));
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_abort_decode", e_fetch(2'b01));
        step("rst_ldr_decode", e_decode(2'b01));
        step("rst_ldr_memadr", e_memadr(2'b01));
        step("rst_ldr_memread", e_memrd(2'b01));
        // Reset mid-MEMREAD: outputs hold until the edge, then FETCH.
        reset = 1'b1;
        #1 check("memread_no_comb_reset", e_memrd(2'b01));
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_mid_memread", e_fetch(2'b01));
        step("rec_decode", e_decode(2'b01));
        step("rec_memadr", e_memadr(2'b01));
        // Decode outputs follow Op without a clock edge.
        dif.Op = 2'b10;
        #1 check("immsrc_follows_op", e_memadr(2'b10));
        step("rec_memread", e_memrd(2'b10));
        step("rec_memwb_rd3", e_memwb(2'b10, 1'b0));
        // PCS follows Rd combinationally while RegW is high.
        dif.Rd = 4'hF;
        #1 check("pcs_follows_rd", e_memwb(2'b10, 1'b1));
        step("rec_refetch", e_fetch(2'b10));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
